// File: rtl/kbd_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// kbd_rx_fifo_pkg
// Shared constants for the keyboard receive FIFO: bus addresses, STATUS/CTRL
// bit positions, the default interrupt vector and a helper that packs the
// STATUS word.
// -----------------------------------------------------------------------------
package kbd_rx_fifo_pkg;

  // DATA word address of the keyboard block; STATUS/CTRL sits one word above.
  localparam logic [63:0] KEY_BASE     = 64'h0000_0000_1000_0000;
  localparam logic [63:0] KEY_STAT_OFF = 64'd8;

  // STATUS word bit positions.
  localparam int STAT_NONEMPTY_BIT = 0;
  localparam int STAT_FULL_BIT     = 1;
  localparam int STAT_OVF_BIT      = 2;
  localparam int STAT_IRQ_EN_BIT   = 3;
  localparam int STAT_COUNT_LSB    = 8;

  // CTRL word bit positions.
  localparam int CTRL_IRQ_EN_BIT  = 0;
  localparam int CTRL_OVF_CLR_BIT = 2;

  // Vector presented to the CPU while a keyboard interrupt is pending.
  localparam logic [3:0] KEY_IRQ_VEC = 4'd1;

  typedef struct packed {
    logic       nonempty;
    logic       full;
    logic       overflow;
    logic       irq_en;
    logic [7:0] count;
  } kbd_status_t;

  // Places the status fields at their bus positions; all other bits are zero.
  function automatic logic [63:0] pack_status(input kbd_status_t s);
    logic [63:0] w;
    w                                      = 64'd0;
    w[STAT_NONEMPTY_BIT]                   = s.nonempty;
    w[STAT_FULL_BIT]                       = s.full;
    w[STAT_OVF_BIT]                        = s.overflow;
    w[STAT_IRQ_EN_BIT]                     = s.irq_en;
    w[STAT_COUNT_LSB +: 8]                 = s.count;
    return w;
  endfunction

endpackage

// File: rtl/kbd_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// kbd_rx_fifo_if
// CPU-side bus and interrupt signals of the keyboard receive FIFO.
//   master : CPU / bus controller (drives address, strobes, write data, ack)
//   slave  : kbd_rx_fifo (drives read data, select, interrupt vector)
// -----------------------------------------------------------------------------
interface kbd_rx_fifo_if;

  logic [63:0] bus_address;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [63:0] bus_write_data;
  logic [63:0] bus_read_data;
  logic        sel;
  logic [3:0]  interrupt_vector;
  logic        interrupt_ack;

  modport master (
    output bus_address,
    output bus_read_enable,
    output bus_write_enable,
    output bus_write_data,
    output interrupt_ack,
    input  bus_read_data,
    input  sel,
    input  interrupt_vector
  );

  modport slave (
    input  bus_address,
    input  bus_read_enable,
    input  bus_write_enable,
    input  bus_write_data,
    input  interrupt_ack,
    output bus_read_data,
    output sel,
    output interrupt_vector
  );

endinterface

// File: rtl/kbd_rx_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with combinational head read-out. Generic so it can also
// back a UART transmit buffer.
//   clk, reset_n : clock, synchronous active-low reset
//   push, din    : write request and data (ignored when full unless popping)
//   pop          : remove head entry (ignored when empty)
//   dout         : current head entry (combinational)
//   count        : number of stored entries, 0..DEPTH
//   full, empty  : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == {CW{1'b0}});
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/kbd_rx_fifo.sv
// -----------------------------------------------------------------------------
// kbd_rx_fifo
// Buffers ASCII key events from the PS/2 decoder so the CPU cannot miss
// keystrokes, and presents them through a DATA word (BASE) and a STATUS/CTRL
// word (BASE+8). Raises a registered interrupt vector on each accepted key.
//   clk, reset_n     : system clock, synchronous active-low reset
//   key_pressed      : high while a key is held
//   ascii            : key code, valid while key_pressed is high
//   bus (slave)      : address, read/write strobes, write data, registered
//                      read data, combinational select, interrupt vector/ack
//   overflow         : sticky flag, a key event was dropped
// -----------------------------------------------------------------------------
module kbd_rx_fifo
  import kbd_rx_fifo_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter logic [63:0] BASE    = KEY_BASE,
  parameter logic [3:0]  IRQ_VEC = KEY_IRQ_VEC
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          key_pressed,
  input  logic [7:0]    ascii,
  kbd_rx_fifo_if.slave  bus,
  output logic          overflow
);

  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [63:0] STAT_ADR = BASE + KEY_STAT_OFF;

  // Edge-detect history and architectural state.
  logic        key_pressed_q, key_pressed_d;
  logic        rd_data_stb_q, rd_data_stb_d;
  logic        rd_stat_stb_q, rd_stat_stb_d;
  logic        wr_ctrl_stb_q, wr_ctrl_stb_d;
  logic        overflow_q, overflow_d;
  logic        irq_en_q, irq_en_d;
  logic        irq_pending_q, irq_pending_d;
  logic [3:0]  irq_vec_q, irq_vec_d;
  logic [63:0] bus_rdata_q, bus_rdata_d;

  // Decoded strobes and single-cycle events.
  logic        rd_data_stb;
  logic        rd_stat_stb;
  logic        wr_ctrl_stb;
  logic        rd_data_rise;
  logic        rd_stat_rise;
  logic        wr_ctrl_rise;
  logic        push_req;
  logic        push_acc;
  logic        pop;
  logic        drop;

  // FIFO view.
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  kbd_status_t   status;

  // Write-data bits with no CTRL meaning; gathered so they read as intentionally unused.
  logic unused_wdata;
  assign unused_wdata = ^{bus.bus_write_data[63:3], bus.bus_write_data[1]};

  assign bus.sel     = (bus.bus_address == BASE) | (bus.bus_address == STAT_ADR);
  assign rd_data_stb = bus.bus_read_enable  & (bus.bus_address == BASE);
  assign rd_stat_stb = bus.bus_read_enable  & (bus.bus_address == STAT_ADR);
  assign wr_ctrl_stb = bus.bus_write_enable & (bus.bus_address == STAT_ADR);

  // Strobes may be held for many cycles; act only on their first cycle.
  assign rd_data_rise = rd_data_stb & ~rd_data_stb_q;
  assign rd_stat_rise = rd_stat_stb & ~rd_stat_stb_q;
  assign wr_ctrl_rise = wr_ctrl_stb & ~wr_ctrl_stb_q;

  assign push_req = key_pressed & ~key_pressed_q & (ascii != 8'd0);
  assign pop      = rd_data_rise & ~fifo_empty;
  // A full FIFO still accepts the key if the head is popped in the same cycle.
  assign push_acc = push_req & (~fifo_full | pop);
  assign drop     = push_req & fifo_full & ~pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_acc),
    .pop     (pop),
    .din     (ascii),
    .dout    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Snapshot of the STATUS fields as seen before this cycle's updates.
  always_comb begin
    status          = '0;
    status.nonempty = ~fifo_empty;
    status.full     = fifo_full;
    status.overflow = overflow_q;
    status.irq_en   = irq_en_q;
    status.count    = 8'(fifo_count);
  end

  // Next-state for edge history, control bits, interrupt and read data.
  always_comb begin
    key_pressed_d = key_pressed;
    rd_data_stb_d = rd_data_stb;
    rd_stat_stb_d = rd_stat_stb;
    wr_ctrl_stb_d = wr_ctrl_stb;

    irq_en_d = irq_en_q;
    if (wr_ctrl_rise) begin
      irq_en_d = bus.bus_write_data[CTRL_IRQ_EN_BIT];
    end else begin
      irq_en_d = irq_en_q;
    end

    // A drop in the same cycle as a clear leaves overflow set.
    overflow_d = overflow_q;
    if (wr_ctrl_rise && bus.bus_write_data[CTRL_OVF_CLR_BIT]) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_d;
    end

    // Disabling interrupts wins; a new key wins over a concurrent ack.
    irq_pending_d = irq_pending_q;
    if (!irq_en_d) begin
      irq_pending_d = 1'b0;
    end else if (push_acc) begin
      irq_pending_d = 1'b1;
    end else if (bus.interrupt_ack && irq_pending_q) begin
      irq_pending_d = 1'b0;
    end else begin
      irq_pending_d = irq_pending_q;
    end
    irq_vec_d = irq_pending_d ? IRQ_VEC : 4'd0;

    // Read data is held until the next accepted read.
    bus_rdata_d = bus_rdata_q;
    if (rd_data_rise) begin
      bus_rdata_d = fifo_empty ? 64'd0 : {56'd0, fifo_head};
    end else if (rd_stat_rise) begin
      bus_rdata_d = pack_status(status);
    end else begin
      bus_rdata_d = bus_rdata_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_pressed_q <= 1'b0;
      rd_data_stb_q <= 1'b0;
      rd_stat_stb_q <= 1'b0;
      wr_ctrl_stb_q <= 1'b0;
      overflow_q    <= 1'b0;
      irq_en_q      <= 1'b1;
      irq_pending_q <= 1'b0;
      irq_vec_q     <= 4'd0;
      bus_rdata_q   <= 64'd0;
    end else begin
      key_pressed_q <= key_pressed_d;
      rd_data_stb_q <= rd_data_stb_d;
      rd_stat_stb_q <= rd_stat_stb_d;
      wr_ctrl_stb_q <= wr_ctrl_stb_d;
      overflow_q    <= overflow_d;
      irq_en_q      <= irq_en_d;
      irq_pending_q <= irq_pending_d;
      irq_vec_q     <= irq_vec_d;
      bus_rdata_q   <= bus_rdata_d;
    end
  end

  assign bus.bus_read_data    = bus_rdata_q;
  assign bus.interrupt_vector = irq_vec_q;
  assign overflow             = overflow_q;

endmodule

// File: doc/kbd_rx_fifo.md
Name: kbd_rx_fifo

Overview:
- Buffers ASCII key events from ps2_decoder into a small FIFO so the CPU does not lose keystrokes while the core runs on the slow clock.
- Sits between ps2_decoder and the bus controller. It replaces the direct ascii-to-bus_read_data path for Key_base.
- Exposes DATA and STATUS/CTRL words on the bus and drives a one-shot interrupt request toward the riscv64 interrupt_vector input.

Parameters:
- DEPTH, 8: FIFO entries. Must be a power of 2, range 2..128.
- BASE, `Key_base: DATA word address. STATUS/CTRL is at BASE+8.
- IRQ_VEC, 4'd1: value driven on interrupt_vector while an interrupt is pending.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- key_pressed  in  1  level from ps2_decoder, high while a key is held
- ascii  in  8  ASCII code from ps2_decoder, valid while key_pressed is high
- bus_address  in  64  byte address from the CPU
- bus_read_enable  in  1  CPU read strobe (may be held for many clk cycles)
- bus_write_enable  in  1  CPU write strobe (may be held for many clk cycles)
- bus_write_data  in  64  CPU write data
- bus_read_data  out  64  registered read data
- sel  out  1  combinational: bus_address is BASE or BASE+8
- interrupt_vector  out  4  IRQ_VEC while an interrupt is pending, else 0
- interrupt_ack  in  1  CPU acknowledge
- overflow  out  1  sticky flag: an event was dropped

Behaviour:
- Reset (reset_n low at a clk edge): FIFO empty, count=0, bus_read_data=0, interrupt_vector=0, overflow=0, irq_en=1, all edge-detect registers cleared. A reset mid-transaction discards all FIFO contents.
- Push:
  - Fires on the clk cycle where key_pressed rises (key_pressed & !key_pressed_q) and ascii != 0. Only one push per press.
  - Zero ascii is ignored.
- Full:
  - Push while count==DEPTH drops the event and sets overflow.
  - If a pop occurs in the same cycle, the push is accepted and overflow is not set.
- Read strobes:
  - rd_data = bus_read_enable & (bus_address==BASE).
  - rd_stat = bus_read_enable & (bus_address==BASE+8).
  - Actions fire once, on the rising edge of each strobe (strobe & !strobe_q).
- DATA read:
  - One cycle after the rising edge, bus_read_data = {56'd0, head}. The head entry is then popped.
  - Empty: bus_read_data = 0 and no state change.
- STATUS read, one cycle after the rising edge, bus_read_data contains:
  - [0] nonempty
  - [1] full
  - [2] overflow
  - [3] irq_en
  - [15:8] count
  - all other bits 0
- Read data hold: bus_read_data holds its value until the next accepted read. It is not cleared between reads.
- CTRL write, on the rising edge of bus_write_enable & (bus_address==BASE+8):
  - bit0 loads irq_en.
  - bit2=1 clears overflow.
  - If a drop occurs in the same cycle as the clear, overflow ends up set.
- Writes to DATA: ignored.
- Simultaneous push and pop: both occur and count is unchanged. When the FIFO is empty, the pop returns 0 and the push still lands.
- Pointers: log2(DEPTH) bits, wrapping naturally. count is log2(DEPTH)+1 bits.
- Interrupt:
  - pending sets on an accepted push when irq_en=1.
  - pending clears when interrupt_ack=1 and pending=1.
  - If a push and an ack occur in the same cycle, pending stays 1.
  - interrupt_vector is registered: IRQ_VEC when pending, else 0.
  - Clearing irq_en also clears pending.

Decomposition:
- header.vh holds Key_base, KEY_STAT_OFF (8), the STATUS bit indices and KEY_IRQ_VEC.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Ports: push, pop, din, dout, count, full, empty.
  - Read data is combinational from head.
  - Reused later for a UART TX buffer.
- Edge detection, register decode and IRQ logic stay in kbd_rx_fifo.

Test Plan:
- Reset, then three presses 'a','b','c' (0x61,0x62,0x63) -> STATUS reads count=3, nonempty=1. Three DATA reads return 0x61, 0x62, 0x63 in order. A fourth DATA read returns 0 and count stays 0.
- Hold bus_read_enable on DATA for 100 cycles with 2 entries present -> exactly one pop; count goes 2->1.
- 9 presses with DEPTH=8 -> count=8, full=1, overflow=1, and the 9th code is lost. Write CTRL with bit2=1 -> overflow=0 while the data is retained.
- Push plus interrupt_ack in the same cycle while pending -> interrupt_vector stays 1. A lone ack -> interrupt_vector=0 on the next cycle.
- CTRL write of 0 (irq_en=0), then a press -> interrupt_vector stays 0 and count increments.
- Full FIFO: a press coincides with the DATA read rising edge -> the push is accepted, count stays 8, overflow stays 0. Then assert reset_n=0 for one cycle -> count=0, bus_read_data=0.
